// File: rtl/conv_pkg.sv
// Shared widths, geometry and tap-index helpers for the 3x3 streaming convolution.
package conv_pkg;

    localparam int unsigned PIX_W  = 8;   // unsigned pixel
    localparam int unsigned WGT_W  = 8;   // signed kernel weight
    localparam int unsigned PROD_W = 17;  // 9-bit zero-extended pixel x 8-bit signed weight
    localparam int unsigned SUM_W  = 21;  // nine products plus growth
    localparam int unsigned OUT_W  = 32;  // AXIS word
    localparam int unsigned KDIM   = 3;
    localparam int unsigned NROWS  = 5;

    localparam int unsigned NWIN   = NROWS - KDIM + 1;  // vertically stacked windows
    localparam int unsigned NTAPS  = KDIM * KDIM;
    localparam int unsigned NPROD  = NWIN * NTAPS;
    localparam int unsigned KERN_W = NTAPS * WGT_W;
    localparam int unsigned ROW_W  = KDIM * PIX_W;

    // Kernel byte lane for (row, col); row 0 is the top row.
    function automatic int tap_idx(int row, int col);
        return row * int'(KDIM) + col;
    endfunction

    // Flat product slot for window win, kernel tap (row, col).
    function automatic int prod_idx(int win, int row, int col);
        return win * int'(NTAPS) + tap_idx(row, col);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Result queue: three entries written per push, one entry read per pop.
module result_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 32,
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [3*Width-1:0]   wdata_i,
    input  logic                 pop_i,
    output logic [Width-1:0]     rdata_o,
    output logic                 empty_o,
    output logic [CntW-1:0]      count_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             pop_ok;

    assign pop_ok  = pop_i & (count_q != '0);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy update; a push adds three, a pop removes one.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(3);
            count_d  = count_d + CntW'(3);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_d - CntW'(1);
        end
    end

    // Control state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; entry 0 of the push lands first in read order.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q]          <= wdata_i[0*Width +: Width];
            mem_q[wr_ptr_q + AW'(1)] <= wdata_i[1*Width +: Width];
            mem_q[wr_ptr_q + AW'(2)] <= wdata_i[2*Width +: Width];
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Three stacked 3x3 convolutions per pixel beat, queued and sent out on AXI-Stream.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int unsigned OUT_LEN    = 12,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_aresetn,
    input  logic [KERN_W-1:0] wdata,
    input  logic              wdata_v,
    input  logic [ROW_W-1:0]  pdata1,
    input  logic [ROW_W-1:0]  pdata2,
    input  logic [ROW_W-1:0]  pdata3,
    input  logic [ROW_W-1:0]  pdata4,
    input  logic [ROW_W-1:0]  pdata5,
    input  logic              pdata_v,
    output logic              pdata_ready,
    output logic              m_axis_tvalid,
    output logic [OUT_W-1:0]  m_axis_tdata,
    output logic [3:0]        m_axis_tstrb,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
);

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] LAST_IDX = 16'(OUT_LEN - 1);

    logic [ROW_W-1:0]         rows [NROWS];
    logic [KERN_W-1:0]        kernel_q;
    logic                     accept;

    logic signed [PROD_W-1:0] prod_d [NPROD];
    logic signed [PROD_W-1:0] prod_q [NPROD];
    logic                     s1_valid_q;

    logic signed [SUM_W-1:0]  sum_d [NWIN];
    logic signed [SUM_W-1:0]  sum_q [NWIN];
    logic                     s2_valid_q;

    logic [3*OUT_W-1:0]       push_data;
    logic [OUT_W-1:0]         fifo_head;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic                     pop;

    logic [15:0]              beat_cnt_q, beat_cnt_d;

    assign accept = pdata_v & pdata_ready;

    // Pixel rows as an array, top row first.
    always_comb begin
        rows[0] = pdata1;
        rows[1] = pdata2;
        rows[2] = pdata3;
        rows[3] = pdata4;
        rows[4] = pdata5;
    end

    // Kernel register; a beat accepted alongside a load still sees the old kernel.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            kernel_q <= '0;
        end else if (wdata_v) begin
            kernel_q <= wdata;
        end
    end

    // All 27 products of the incoming beat; the pixel is zero-extended before the signed multiply.
    always_comb begin
        for (int i = 0; i < int'(NPROD); i++) begin
            prod_d[i] = '0;
        end
        for (int w = 0; w < int'(NWIN); w++) begin
            for (int r = 0; r < int'(KDIM); r++) begin
                for (int c = 0; c < int'(KDIM); c++) begin
                    prod_d[prod_idx(w, r, c)] =
                        PROD_W'($signed({1'b0, rows[w + r][c*PIX_W +: PIX_W]})) *
                        PROD_W'($signed(kernel_q[tap_idx(r, c)*WGT_W +: WGT_W]));
                end
            end
        end
    end

    // Pipeline valids.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
        end
    end

    // Stage 1 product register.
    always_ff @(posedge m_axis_aclk) begin
        if (accept) begin
            prod_q <= prod_d;
        end
    end

    // Nine-term sum per window.
    always_comb begin
        for (int w = 0; w < int'(NWIN); w++) begin
            sum_d[w] = '0;
            for (int t = 0; t < int'(NTAPS); t++) begin
                sum_d[w] = sum_d[w] + SUM_W'(prod_q[w*int'(NTAPS) + t]);
            end
        end
    end

    // Stage 2 sum register.
    always_ff @(posedge m_axis_aclk) begin
        if (s1_valid_q) begin
            sum_q <= sum_d;
        end
    end

    // Window 0 occupies the low lane so it is read out first.
    assign push_data = {OUT_W'(sum_q[2]), OUT_W'(sum_q[1]), OUT_W'(sum_q[0])};

    result_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (OUT_W)
    ) u_result_fifo (
        .clk_i   (m_axis_aclk),
        .rst_ni  (m_axis_aresetn),
        .push_i  (s2_valid_q),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Reserve room for every beat still in flight so the FIFO can never overflow.
    assign pdata_ready = (int'(fifo_count) + NWIN * (int'(s1_valid_q) + int'(s2_valid_q))
                          + NWIN) <= FIFO_DEPTH;

    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_head;
    assign m_axis_tstrb  = 4'hF;
    assign m_axis_tlast  = (beat_cnt_q == LAST_IDX) & m_axis_tvalid;
    assign pop           = m_axis_tvalid & m_axis_tready;

    // Frame beat counter; wraps on the pop carrying TLAST.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (pop) begin
            beat_cnt_d = (beat_cnt_q == LAST_IDX) ? 16'd0 : beat_cnt_q + 16'd1;
        end
    end

    // Beat counter register.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench: the driver pushes model results on accept, the monitor checks AXIS beats.
module tb_conv3x3_stream;

    localparam int OUT_LEN    = 6;
    localparam int FIFO_DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [71:0]  wdata;
    logic         wdata_v;
    logic [119:0] px_cur;
    logic         pdata_v;
    logic         pdata_ready;
    logic         m_axis_tvalid;
    logic [31:0]  m_axis_tdata;
    logic [3:0]   m_axis_tstrb;
    logic         m_axis_tlast;
    bit           tready_b;
    bit           tready_cmd;
    bit           rand_mode;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [71:0] model_k;
    int          model_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    conv3x3_stream #(
        .OUT_LEN    (OUT_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .wdata          (wdata),
        .wdata_v        (wdata_v),
        .pdata1         (px_cur[0*24 +: 24]),
        .pdata2         (px_cur[1*24 +: 24]),
        .pdata3         (px_cur[2*24 +: 24]),
        .pdata4         (px_cur[3*24 +: 24]),
        .pdata5         (px_cur[4*24 +: 24]),
        .pdata_v        (pdata_v),
        .pdata_ready    (pdata_ready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tstrb   (m_axis_tstrb),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (tready_b)
    );

    // tready: random in the soak phase, otherwise whatever the sequence commands.
    always @(posedge clk) begin
        #2;
        if (rand_mode) tready_b = ($urandom_range(0, 3) != 0);
        else           tready_b = tready_cmd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 3x3 dot product of kernel against pixel rows w..w+2.
    function automatic int win_ref(input logic [71:0] k, input logic [119:0] px, input int w);
        int s = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                s += int'(px[24*(w+r) + 8*c +: 8]) * int'($signed(k[8*(3*r+c) +: 8]));
            end
        end
        return s;
    endfunction

    task automatic push_expected(input logic [71:0] k, input logic [119:0] px);
        exp_t e;
        for (int w = 0; w < 3; w++) begin
            e.data = 32'(win_ref(k, px, w));
            e.last = (model_cnt == OUT_LEN - 1);
            model_cnt = (model_cnt + 1) % OUT_LEN;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [71:0] rand72();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    function automatic logic [119:0] fill_px(input logic [7:0] v);
        return {15{v}};
    endfunction

    // Monitor: checks the head on every valid cycle, pops on handshake.
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got tdata %h, expected no output", m_axis_tdata);
            end else begin
                check("tdata", m_axis_tdata, exp_q[0].data);
                check("tlast", {31'b0, m_axis_tlast}, {31'b0, exp_q[0].last});
                if (tready_b) void'(exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge with pdata_v low.
    task automatic issue(input logic [119:0] px, input logic wnew, input logic [71:0] wval);
        bit got = 0;
        px_cur  = px;
        pdata_v = 1'b1;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (pdata_ready) got = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            check("accept_timeout", 32'(pdata_ready), 32'd1);
            pdata_v = 1'b0;
            return;
        end
        if (wnew) begin
            wdata   = wval;
            wdata_v = 1'b1;
        end
        push_expected(model_k, px);
        if (wnew) model_k = wval;
        @(posedge clk);
        #1;
        pdata_v = 1'b0;
        wdata_v = 1'b0;
    endtask

    task automatic load_kernel(input logic [71:0] k);
        wdata   = k;
        wdata_v = 1'b1;
        @(posedge clk);
        #1;
        wdata_v = 1'b0;
        model_k = k;
    endtask

    task automatic idle(input int n);
        pdata_v = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        model_k   = '0;
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [119:0] px;
        logic [71:0]  kc;
        rst_n = 1'b0; pdata_v = 1'b0; wdata_v = 1'b0; wdata = '0; px_cur = '0;
        tready_cmd = 1'b1; rand_mode = 1'b0; model_k = '0; model_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("reset_tlast", 32'(m_axis_tlast), 32'd0);
        check("reset_tdata", m_axis_tdata, 32'd0);
        check("reset_ready", 32'(pdata_ready), 32'd1);
        check("tstrb", 32'(m_axis_tstrb), 32'hF);

        // All ones: three results of 9, first tvalid two edges after accept.
        load_kernel({9{8'h01}});
        issue(fill_px(8'h01), 1'b0, '0);
        @(negedge clk);
        check("lat_before_n1", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        check("lat_after_n1", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        check("lat_after_n2", 32'(m_axis_tvalid), 32'd1);
        drain(50);

        // Centre tap: 20, 30, 40; beat 6 of the frame carries TLAST.
        load_kernel(72'h00_0000_0001_0000_0000);
        px = '0;
        for (int r = 0; r < 5; r++) px[24*r + 8 +: 8] = 8'(10 * (r + 1));
        issue(px, 1'b0, '0);
        drain(50);

        // -1 x 255: -2295 each; beats 7-9 have TLAST low after the wrap.
        load_kernel({9{8'hFF}});
        issue(fill_px(8'hFF), 1'b0, '0);
        drain(50);

        // Backpressure: two beats fill the FIFO to 6, a third must wait.
        tready_cmd = 1'b0;
        idle(1);
        kc = rand72();
        load_kernel(kc);
        issue(rand72() ^ {rand72(), 48'h0}, 1'b0, '0);
        issue({rand72(), 48'h123456789abc}, 1'b0, '0);
        px_cur  = fill_px(8'h33);
        pdata_v = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ready_full", 32'(pdata_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        check("full_tvalid", 32'(m_axis_tvalid), 32'd1);
        tready_cmd = 1'b1;
        issue(fill_px(8'h33), 1'b0, '0);
        drain(100);

        // Kernel load coincident with accept: old kernel gives 9, next beat 18.
        load_kernel({9{8'h01}});
        issue(fill_px(8'h01), 1'b1, {9{8'h02}});
        issue(fill_px(8'h01), 1'b0, '0);
        drain(50);

        // Reset with results queued: output drops at once and nothing stale returns.
        tready_cmd = 1'b0;
        idle(1);
        issue(fill_px(8'h05), 1'b0, '0);
        issue(fill_px(8'h07), 1'b0, '0);
        idle(4);
        tready_cmd = 1'b1;
        idle(2);
        tready_cmd = 1'b0;
        idle(1);
        assert_reset();
        tready_cmd = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(pdata_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(fill_px(8'h09), 1'b0, '0);  // kernel cleared by reset: zeros
        load_kernel(rand72());
        issue({rand72(), 48'hfedcba987654}, 1'b0, '0);
        drain(50);

        // Random soak: random kernels, pixels, same-cycle loads, gaps and tready.
        rand_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) load_kernel(rand72());
            issue({rand72(), 48'(rand72())}, ($urandom_range(0, 4) == 0), rand72());
            idle($urandom_range(0, 2));
        end
        rand_mode = 1'b0;
        tready_cmd = 1'b1;
        drain(2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Downstream stage of the input buffer: consumes the 72-bit 3x3 kernel (wdata/wdata_v) and five 24-bit pixel rows (pdata1..pdata5/pdata_v).
- Computes three vertically stacked 3x3 convolutions per pixel beat: rows 1-3, 2-4 and 3-5.
- Queues the 32-bit results and sends them to the DMA S2MM path on the M_AXIS master interface, with TLAST framing.

Parameters:
- OUT_LEN, 12, result beats per output frame; TLAST is asserted on the last beat. Range 1..65535.
- FIFO_DEPTH, 8, result FIFO entries; power of two, at least 4.

Ports:
- m_axis_aclk  in  1  sole clock
- m_axis_aresetn  in  1  asynchronous active-low reset
- wdata  in  72  kernel; byte k = wdata[8k+7:8k], k = row*3+col, row 0 = top, signed 8-bit
- wdata_v  in  1  kernel valid, one-cycle strobe
- pdata1..pdata5  in  24 each  pixel rows, pdata1 = top; byte c = column c, unsigned 8-bit
- pdata_v  in  1  pixel beat valid; the beat is accepted when pdata_v and pdata_ready are both high
- pdata_ready  out  1  can accept a pixel beat this cycle
- m_axis_tvalid  out  1  AXIS valid
- m_axis_tdata  out  32  signed result
- m_axis_tstrb  out  4  constant 4'hF
- m_axis_tlast  out  1  frame end
- m_axis_tready  in  1  AXIS ready

Behaviour:
- Reset (asynchronous, low): kernel = 0, FIFO empty, pipeline valids = 0, beat counter = 0. Outputs: m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, pdata_ready = 1 on the first clock after reset release.
- Kernel register:
  - Loaded on any cycle with wdata_v = 1.
  - A pixel beat accepted in the same cycle uses the old kernel.
  - Beats already in the pipeline are unaffected.
- Stage 1 (accept edge): register 27 products, each unsigned 8 x signed 8, computed as 17-bit signed (pixel zero-extended to 9 bits).
- Stage 2 (next edge):
  - Sum each group of nine products into a 21-bit signed value.
  - Sign-extend to 32 bits.
  - Write three results to the FIFO in one cycle, order: window 0 (rows 1-3), window 1, window 2.
- Latency: a beat accepted at edge N makes its results visible in the FIFO at edge N+2. Window 0 appears on m_axis_tdata from edge N+2 at the earliest.
- Throughput: one pixel beat per 3 cycles when m_axis_tready is held at 1. Output rate is 1 result per cycle.
- Flow control:
  - pdata_ready = (FIFO free slots − 3 × (stage 1 valid + stage 2 valid)) ≥ 3.
  - The FIFO never overflows.
  - A beat with pdata_v = 1 and pdata_ready = 0 is ignored; the upstream holds the data.
- AXIS output:
  - m_axis_tvalid = FIFO not empty; tdata = FIFO head.
  - Pop occurs on tvalid & tready.
  - While tvalid = 1 and tready = 0, tdata and tlast stay stable.
- TLAST:
  - Beat counter increments on each pop.
  - m_axis_tlast = (counter == OUT_LEN−1) & tvalid.
  - The counter wraps to 0 on the pop that carries TLAST.
  - Frames may span pixel beats; a window triple may straddle a frame boundary.
- Simultaneous FIFO push (3 entries) and pop (1 entry) in the same cycle: net +2.
- Full FIFO: no push occurs, guaranteed by pdata_ready.
- Empty FIFO: tvalid = 0.
- Reset mid-frame: all in-flight and queued results are discarded and the counter clears. No partial TLAST is generated.

Decomposition:
- Shared package conv_pkg:
  - PIX_W = 8, WGT_W = 8, PROD_W = 17, SUM_W = 21, OUT_W = 32, KDIM = 3, NROWS = 5.
  - Byte-lane index helper constants.
- Sub-module result_fifo:
  - Synchronous FIFO with a 3-entry write port and a 1-entry read port.
  - Occupancy count output, same clock and reset as this block.

Test Plan:
- All kernel bytes 8'h01, all pixels 8'h01, one beat, tready = 1: three beats of 32'h00000009. tlast = 0 with OUT_LEN = 12; first tvalid 2 cycles after accept.
- Kernel center only (byte 4 = 1, others 0); rows 1..5 column 1 = 10, 20, 30, 40, 50: outputs 20, 30, 40 in that order.
- All kernel bytes 8'hFF (−1), all pixels 8'hFF: each output 32'hFFFFF709 (−2295).
- OUT_LEN = 6, two pixel beats: tlast high only on beat 6. A third beat gives beats 7-9 with tlast = 0, showing the counter wrapped.
- FIFO_DEPTH = 8, tready = 0, pdata_v held at 1: two beats accepted, then pdata_ready = 0 with 6 entries queued. Release tready: 6 results drain in order and pdata_ready reasserts.
- wdata_v pulses (all 2) in the same cycle as a pdata accept (kernel all 1, pixels 1): that beat outputs 9. The next beat outputs 18. Assert reset with 4 queued: tvalid = 0 immediately, no stale data after release.
